// File: rtl/latch_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : latch_reader_pkg
// Description : Shared types and constants for the latch_reader block.
// Revision    : 1.0 - initial release
// ============================================================================
package latch_reader_pkg;

    // Debounce FSM: two settled states and two qualification states.
    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    // Legal synchronizer depth range.
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

endpackage
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : Plain flop-chain synchronizer for one asynchronous bit.
//               Reusable for any asynchronous level input.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stages;

    // Shift the input through the chain; no logic between stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[STAGES-2:0], d};
        end
    end

    assign q = stages[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/latch_reader.sv
`default_nettype none
// ============================================================================
// Module      : latch_reader
// Description : Synchronizes a latch output into the clk domain, debounces it,
//               emits rise/fall pulses and offers each accepted level change
//               as a one-entry valid/ready event with sticky overflow.
//               Optional macro LATCH_READER_GLITCH_COUNT_EN adds glitch_cnt,
//               a saturating count of rejected level changes.
// Revision    : 1.0 - initial release
// ============================================================================
module latch_reader
    import latch_reader_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_in,
    output logic       level_out,
    output logic       rise,
    output logic       fall,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       evt_level,
    output logic       evt_overflow,
    input  logic       clr_overflow
`ifdef LATCH_READER_GLITCH_COUNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    // With a one-cycle qualification window the CHECK states are bypassed.
    localparam bit             SINGLE   = (STABLE_CYCLES == 1);

    logic             s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, rise_nxt, fall_nxt;
    logic             accept;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (d_in),
        .q     (s)
    );

    // State, counter and debounced-level registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            level_out <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            level_out <= level_nxt;
            rise      <= rise_nxt;
            fall      <= fall_nxt;
        end
    end

    // Debounce next-state: a new level must hold STABLE_CYCLES samples.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level_out;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (s) begin
                    if (SINGLE) begin
                        state_nxt = IDLE_HIGH;
                        cnt_nxt   = '0;
                        level_nxt = 1'b1;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = CHECK_HIGH;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            CHECK_HIGH: begin
                if (!s) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!s) begin
                    if (SINGLE) begin
                        state_nxt = IDLE_LOW;
                        cnt_nxt   = '0;
                        level_nxt = 1'b0;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = CHECK_LOW;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            CHECK_LOW: begin
                if (s) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign accept = rise_nxt | fall_nxt;

    // One-entry event slot; a new event may replace one being consumed now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            evt_valid    <= 1'b0;
            evt_level    <= 1'b0;
            evt_overflow <= 1'b0;
        end else begin
            if (accept) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_level <= level_nxt;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (accept && evt_valid && !evt_ready) begin
                evt_overflow <= 1'b1;
            end else if (clr_overflow) begin
                evt_overflow <= 1'b0;
            end
        end
    end

`ifdef LATCH_READER_GLITCH_COUNT_EN
    logic       reject;
    logic [7:0] glitch_q;

    // A qualification window abandoned because s returned to the old level.
    assign reject = ((state == CHECK_HIGH) && !s) || ((state == CHECK_LOW) && s);

    // Saturating glitch counter; a clear coinciding with a rejection restarts at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_q <= 8'd0;
        end else if (clr_overflow) begin
            glitch_q <= reject ? 8'd1 : 8'd0;
        end else if (reject && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule
`default_nettype wire
